// File: rtl/pyhdl_if_req_rsp_bridge.sv
// Bridges a DUT req/rsp port to the Python pyhdl_if task API through two FIFOs.
// Optional statistics outputs are enabled by defining PYHDL_IF_REQ_RSP_BRIDGE_STATS_EN.
module pyhdl_if_req_rsp_bridge #(
  parameter int REQ_W           = 32,
  parameter int RSP_W           = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [REQ_W-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RSP_W-1:0] rsp_data,
  output logic             py_req_avail,
  output logic [REQ_W-1:0] py_req_data,
  input  logic             py_req_pop,
  input  logic             py_rsp_push,
  input  logic [RSP_W-1:0] py_rsp_data,
  output logic             py_rsp_space,
  output logic [7:0]       outstanding,
  output logic [1:0]       err
`ifdef PYHDL_IF_REQ_RSP_BRIDGE_STATS_EN
  ,
  output logic [31:0]      stat_req_cnt,
  output logic [31:0]      stat_rsp_cnt,
  output logic [7:0]       stat_max_outstanding
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [REQ_W-1:0] req_mem_q [DEPTH];
  logic [RSP_W-1:0] rsp_mem_q [DEPTH];
  logic [AW:0]      req_wr_q, req_rd_q, rsp_wr_q, rsp_rd_q;
  logic [7:0]       out_q, out_d, pend_q, pend_d;
  logic [1:0]       err_q, err_d;

  logic req_empty, req_full, rsp_empty, rsp_full;
  logic req_hs, req_pop, rsp_hs, rsp_push_ok;

  // Extra pointer MSB differs only when the writer has lapped the reader.
  assign req_empty = (req_wr_q == req_rd_q);
  assign req_full  = (req_wr_q[AW] != req_rd_q[AW]) && (req_wr_q[AW-1:0] == req_rd_q[AW-1:0]);
  assign rsp_empty = (rsp_wr_q == rsp_rd_q);
  assign rsp_full  = (rsp_wr_q[AW] != rsp_rd_q[AW]) && (rsp_wr_q[AW-1:0] == rsp_rd_q[AW-1:0]);

  assign req_ready    = !req_full && (out_q < 8'(MAX_OUTSTANDING)) && !reset;
  assign req_hs       = req_valid && req_ready;
  assign req_pop      = py_req_pop && !req_empty;
  assign rsp_hs       = rsp_valid && rsp_ready;
  assign rsp_push_ok  = py_rsp_push && (pend_q != 8'd0) && !rsp_full;

  assign py_req_avail = !req_empty;
  assign py_req_data  = req_empty ? '0 : req_mem_q[req_rd_q[AW-1:0]];
  assign rsp_valid    = !rsp_empty;
  assign rsp_data     = rsp_empty ? '0 : rsp_mem_q[rsp_rd_q[AW-1:0]];
  assign py_rsp_space = !rsp_full;
  assign outstanding  = out_q;
  assign err          = err_q;

  always_comb begin
    out_d = out_q;
    if (req_hs && !rsp_hs)
      out_d = out_q + 8'd1;
    else if (!req_hs && rsp_hs)
      out_d = out_q - 8'd1;

    pend_d = pend_q;
    if (req_pop && !rsp_push_ok)
      pend_d = pend_q + 8'd1;
    else if (!req_pop && rsp_push_ok)
      pend_d = pend_q - 8'd1;

    // Zero check uses the pre-cycle pending count.
    err_d = err_q | {py_rsp_push && (pend_q != 8'd0) && rsp_full,
                     py_rsp_push && (pend_q == 8'd0)};
  end

  always_ff @(posedge clock) begin
    if (req_hs)
      req_mem_q[req_wr_q[AW-1:0]] <= req_data;
    if (rsp_push_ok)
      rsp_mem_q[rsp_wr_q[AW-1:0]] <= py_rsp_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_wr_q <= '0;
      req_rd_q <= '0;
      rsp_wr_q <= '0;
      rsp_rd_q <= '0;
      out_q    <= '0;
      pend_q   <= '0;
      err_q    <= '0;
    end else begin
      if (req_hs)      req_wr_q <= req_wr_q + 1'b1;
      if (req_pop)     req_rd_q <= req_rd_q + 1'b1;
      if (rsp_push_ok) rsp_wr_q <= rsp_wr_q + 1'b1;
      if (rsp_hs)      rsp_rd_q <= rsp_rd_q + 1'b1;
      out_q  <= out_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

`ifdef PYHDL_IF_REQ_RSP_BRIDGE_STATS_EN
  logic [31:0] stat_req_q, stat_rsp_q;
  logic [7:0]  stat_max_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_req_q <= '0;
      stat_rsp_q <= '0;
      stat_max_q <= '0;
    end else begin
      if (req_hs)             stat_req_q <= stat_req_q + 32'd1;
      if (rsp_hs)             stat_rsp_q <= stat_rsp_q + 32'd1;
      if (out_d > stat_max_q) stat_max_q <= out_d;
    end
  end

  assign stat_req_cnt         = stat_req_q;
  assign stat_rsp_cnt         = stat_rsp_q;
  assign stat_max_outstanding = stat_max_q;
`endif

endmodule
